ps2_key_decoder: RTL
====================

Name: ps2_key_decoder

Overview:
- Consumes raw PS/2 scan-code bytes (key_en/key_data) from the PS/2 controller and assembles them into complete key events: keycode, make/break, extended flag.
- Tracks the four arrow keys and presents a single registered movement code (move) to the game logic inside system.
- Lives in system, directly downstream of PS2_Controller. It drives the keycode/key_make/key_ext/move signals shown on HEX/LEDG.

Parameters:
- TIMEOUT_CYCLES, 2500000, max clk cycles between bytes of one multi-byte sequence before it is discarded (50 ms at 50 MHz).
- TO_W, 22, width of the timeout counter; must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock, 50 MHz
- reset  in  1  asynchronous, active-high reset
- key_en  in  1  one-cycle strobe: key_data valid
- key_data  in  8  received scan-code byte
- keycode  out  8  final code byte of last completed event (prefixes stripped)
- key_make  out  1  1 = last event was press, 0 = release
- key_ext  out  1  1 = last event carried E0 prefix
- key_valid  out  1  one-cycle pulse when keycode/key_make/key_ext update
- key_repeat  out  1  with key_valid: typematic make of an already-held arrow
- held  out  4  arrow held flags {right,left,down,up}
- move  out  3  0 none, 1 up, 2 down, 3 left, 4 right

Behaviour:
- Async reset: state IDLE, timeout counter 0, every output 0.
- FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen). Only key_en cycles advance it.
- IDLE:
  - E0 -> EXT.
  - F0 -> BRK.
  - E1, AA, FA, EE, FC -> dropped, stay IDLE, no event.
  - Any other byte -> make event, ext=0.
- EXT:
  - F0 -> EXT_BRK.
  - 12 or 59 (fake shift) -> IDLE, no event.
  - Any other byte -> make event, ext=1, -> IDLE.
- BRK: any byte -> break event, ext=0, -> IDLE.
- EXT_BRK:
  - 12 or 59 -> IDLE, no event.
  - Any other byte -> break event, ext=1, -> IDLE.
- Event latency: keycode/key_make/key_ext/key_repeat/held/move are registered together. key_valid is high exactly 1 cycle, the cycle after the completing key_en. Event outputs hold until the next event; key_repeat clears when key_valid drops.
- Timeout:
  - Counter clears on every key_en.
  - In non-IDLE states it increments each cycle. At TIMEOUT_CYCLES-1 the FSM returns to IDLE with no event.
  - If key_en and expiry fall in the same cycle, key_en wins: the byte is processed in the current state.
- Arrow tracking, only ext=1 with codes 75 up, 72 down, 6B left, 74 right:
  - Make: sets the held bit. key_repeat=1 if the bit was already set. move = that arrow, including on repeat.
  - Break: clears the bit.
    - If it was the current move, move falls back to the highest remaining held arrow, priority up>down>left>right; 0 if none.
    - Otherwise move is unchanged.
  - Break of a not-held arrow: held unchanged, event still emitted.
  - Non-arrow events leave held/move unchanged; key_repeat=0.
- Back-to-back key_en on consecutive cycles must be accepted without loss.
- Reset mid-sequence: prefix state is discarded, held/move clear.

Decomposition:
- Package ps2_key_pkg holds:
  - byte constants: E0, F0, E1, AA, FA, EE, FC, fake-shift 12/59, the four arrow codes;
  - FSM state encoding;
  - MOVE_NONE/UP/DOWN/LEFT/RIGHT codes.
- One sub-module, ps2_arrow_tracker: inputs are the event strobe, code, make and ext. It owns held, move and key_repeat. The top keeps the FSM, timeout and event registers.

Test Plan:
- Byte 1C -> key_valid pulse 1 cycle later; keycode=1C, key_make=1, key_ext=0; move=0.
- E0 75 -> make, ext=1, move=1, held=0001. Repeating E0 75 -> key_repeat=1, move=1. Then E0 F0 75 -> break, held=0000, move=0.
- Press up (E0 75), then left (E0 6B) -> move=3. Release left (E0 F0 6B) -> move=1. Release up -> move=0.
- E0 12 E0 74 (fake shift + right) -> only one event: keycode=74, ext=1, move=4.
- F0, then idle TIMEOUT_CYCLES cycles, then 1C -> make of 1C (not break), no event at timeout. Repeat with key_en landing on the expiry cycle -> processed as break.
- Assert reset after E0 F0 -> all outputs 0. Next byte 75 -> make, ext=0, move=0.

Source files
------------

// File: rtl/ps2_key_pkg.sv
// Shared constants, types and helpers for the PS/2 key decoder:
// scan-code bytes, prefix FSM states and arrow movement codes.
package ps2_key_pkg;

  localparam logic [7:0] BYTE_E0    = 8'hE0;
  localparam logic [7:0] BYTE_F0    = 8'hF0;
  localparam logic [7:0] BYTE_E1    = 8'hE1;
  localparam logic [7:0] BYTE_AA    = 8'hAA;
  localparam logic [7:0] BYTE_FA    = 8'hFA;
  localparam logic [7:0] BYTE_EE    = 8'hEE;
  localparam logic [7:0] BYTE_FC    = 8'hFC;
  localparam logic [7:0] FAKE_SH_12 = 8'h12;
  localparam logic [7:0] FAKE_SH_59 = 8'h59;
  localparam logic [7:0] ARROW_UP    = 8'h75;
  localparam logic [7:0] ARROW_DOWN  = 8'h72;
  localparam logic [7:0] ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] ARROW_RIGHT = 8'h74;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    MOVE_NONE  = 3'd0,
    MOVE_UP    = 3'd1,
    MOVE_DOWN  = 3'd2,
    MOVE_LEFT  = 3'd3,
    MOVE_RIGHT = 3'd4
  } move_e;

  // Bytes that carry no key information when seen outside a sequence.
  function automatic logic is_dropped(input logic [7:0] code);
    return (code == BYTE_E1) || (code == BYTE_AA) || (code == BYTE_FA) ||
           (code == BYTE_EE) || (code == BYTE_FC);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] code);
    return (code == FAKE_SH_12) || (code == FAKE_SH_59);
  endfunction

  // One-hot {right,left,down,up}; zero for non-arrow codes.
  function automatic logic [3:0] arrow_onehot(input logic [7:0] code);
    case (code)
      ARROW_UP:    return 4'b0001;
      ARROW_DOWN:  return 4'b0010;
      ARROW_LEFT:  return 4'b0100;
      ARROW_RIGHT: return 4'b1000;
      default:     return 4'b0000;
    endcase
  endfunction

  // Priority up > down > left > right; also maps a one-hot arrow to its code.
  function automatic move_e move_from_held(input logic [3:0] held);
    if (held[0]) return MOVE_UP;
    if (held[1]) return MOVE_DOWN;
    if (held[2]) return MOVE_LEFT;
    if (held[3]) return MOVE_RIGHT;
    return MOVE_NONE;
  endfunction

endpackage

// File: rtl/ps2_arrow_tracker.sv
// Tracks which arrow keys are held and derives the registered movement code
// and typematic-repeat flag from completed key events.
module ps2_arrow_tracker
  import ps2_key_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       ev_valid,
  input  logic [7:0] ev_code,
  input  logic       ev_make,
  input  logic       ev_ext,
  output logic [3:0] held,
  output logic [2:0] move,
  output logic       key_repeat
);

  logic [3:0] held_q, held_d;
  move_e      move_q, move_d;
  logic       repeat_q, repeat_d;
  logic [3:0] arrow;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    held_d   = held_q;
    move_d   = move_q;
    repeat_d = 1'b0;
    arrow    = ev_ext ? arrow_onehot(ev_code) : 4'b0000;
    if (ev_valid && (arrow != 4'b0000)) begin
      if (ev_make) begin
        repeat_d = |(held_q & arrow);
        held_d   = held_q | arrow;
        move_d   = move_from_held(arrow);
      end else begin
        held_d = held_q & ~arrow;
        // Releasing the active direction falls back to the best remaining one.
        if (move_q == move_from_held(arrow)) move_d = move_from_held(held_d);
      end
    end
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      held_q   <= 4'b0000;
      move_q   <= MOVE_NONE;
      repeat_q <= 1'b0;
    end else begin
      held_q   <= held_d;
      move_q   <= move_d;
      repeat_q <= repeat_d;
    end
  end

  assign held       = held_q;
  assign move       = move_q;
  assign key_repeat = repeat_q;

endmodule

// File: rtl/ps2_key_decoder.sv
// Assembles raw PS/2 scan-code bytes into key events (code, make/break, E0 flag),
// discarding stale prefixes after a timeout, and tracks arrow-key movement.
module ps2_key_decoder
  import ps2_key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 2500000,
  parameter int TO_W           = 22
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_en,
  input  logic [7:0] key_data,
  output logic [7:0] keycode,
  output logic       key_make,
  output logic       key_ext,
  output logic       key_valid,
  output logic       key_repeat,
  output logic [3:0] held,
  output logic [2:0] move
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [7:0]      keycode_q, keycode_d;
  logic            make_q, make_d;
  logic            ext_q, ext_d;
  logic            valid_q;
  logic            ev_valid, ev_make, ev_ext;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ev_valid = 1'b0;
    ev_make  = 1'b0;
    ev_ext   = 1'b0;
    if (key_en) begin
      // A byte arriving on the expiry cycle still belongs to the open sequence.
      cnt_d = '0;
      case (state_q)
        ST_IDLE: begin
          if (key_data == BYTE_E0)      state_d = ST_EXT;
          else if (key_data == BYTE_F0) state_d = ST_BRK;
          else if (!is_dropped(key_data)) begin
            ev_valid = 1'b1;
            ev_make  = 1'b1;
          end
        end
        ST_EXT: begin
          if (key_data == BYTE_F0) state_d = ST_EXT_BRK;
          else begin
            state_d = ST_IDLE;
            if (!is_fake_shift(key_data)) begin
              ev_valid = 1'b1;
              ev_make  = 1'b1;
              ev_ext   = 1'b1;
            end
          end
        end
        ST_BRK: begin
          state_d  = ST_IDLE;
          ev_valid = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          if (!is_fake_shift(key_data)) begin
            ev_valid = 1'b1;
            ev_ext   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (cnt_q == TO_LAST) begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end
  end

  always_comb begin
    keycode_d = ev_valid ? key_data : keycode_q;
    make_d    = ev_valid ? ev_make  : make_q;
    ext_d     = ev_valid ? ev_ext   : ext_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      keycode_q <= 8'h00;
      make_q    <= 1'b0;
      ext_q     <= 1'b0;
      valid_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      keycode_q <= keycode_d;
      make_q    <= make_d;
      ext_q     <= ext_d;
      valid_q   <= ev_valid;
    end
  end

  ps2_arrow_tracker u_arrow (
    .clk        (clk),
    .reset      (reset),
    .ev_valid   (ev_valid),
    .ev_code    (key_data),
    .ev_make    (ev_make),
    .ev_ext     (ev_ext),
    .held       (held),
    .move       (move),
    .key_repeat (key_repeat)
  );

  assign keycode   = keycode_q;
  assign key_make  = make_q;
  assign key_ext   = ext_q;
  assign key_valid = valid_q;

endmodule
